// File: rtl/self_trigger_frame_capture_pkg.sv
// Shared constants and types for the self-trigger frame capture block.
package self_trigger_frame_capture_pkg;

    // First header byte, lets the readout find frame starts in a raw stream
    localparam logic [7:0] HDR_MARKER = 8'hA5;
    // Header words ahead of the samples: marker/channel + 3 timestamp words
    localparam int unsigned HDR_LEN = 4;

    typedef enum logic [2:0] {
        StFill,
        StArmed,
        StPost,
        StHdr,
        StData
    } state_e;

    // Ring pointer width for a power-of-two depth
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sample_ring_ram.sv
// Simple dual-port sample ring storage with a registered read port (1 clk latency).
module sample_ring_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [DEPTH];

    // Write port and enabled registered read; rd_data holds when rd_en is low
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/self_trigger_frame_capture.sv
// Captures a pre/post-trigger window of raw samples into a ring buffer and streams it
// out as a framed valid/ready packet: 4 header words followed by WINDOW samples.
module self_trigger_frame_capture
    import self_trigger_frame_capture_pkg::*;
#(
    parameter int unsigned PRE_SAMPLES = 64,
    parameter int unsigned WINDOW      = 256,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned CHANNEL_ID  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [15:0] din,
    input  logic               trigger,
    input  logic        [47:0] timestamp,
    output logic        [15:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               busy,
    output logic        [15:0] drop_count
);

    localparam int unsigned PW = ptr_width(DEPTH);
    // Counters get one spare bit so WINDOW and 4+WINDOW always fit
    localparam int unsigned CW = PW + 1;

    localparam logic [PW-1:0] PRE_OFS   = PW'(PRE_SAMPLES);
    localparam logic [CW-1:0] PRE_CNT   = CW'(PRE_SAMPLES);
    localparam logic [CW-1:0] POST_CNT  = CW'(WINDOW - PRE_SAMPLES);
    localparam logic [CW-1:0] WIN_CNT   = CW'(WINDOW);
    localparam logic [CW-1:0] HDR_CNT   = CW'(HDR_LEN);
    localparam logic [CW-1:0] FRAME_CNT = CW'(HDR_LEN + WINDOW);
    localparam logic [7:0]    CH_ID     = 8'(CHANNEL_ID);

    state_e        state;
    logic          trigger_d;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] start_ptr;
    logic [PW-1:0] rd_addr;
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] post_cnt;
    logic [CW-1:0] out_cnt;   // words loaded into the output register this frame
    logic [CW-1:0] rd_cnt;    // RAM reads issued this frame
    logic          pf_valid;  // RAM read register holds an unconsumed sample
    logic [47:0]   ts_lat;
    logic [15:0]   rd_data;
    logic [15:0]   hdr_word;

    logic trig_evt;
    logic wr_en;
    logic out_active;
    logic xfer;
    logic advance;
    logic hdr_load;
    logic pf_take;
    logic rd_en;
    logic frame_done;

    assign trig_evt   = trigger & ~trigger_d;
    assign wr_en      = enable & ((state == StFill) | (state == StArmed) | (state == StPost));
    assign out_active = (state == StHdr) | (state == StData);
    assign xfer       = dout_valid & dout_ready;
    assign advance    = ~dout_valid | dout_ready;
    assign hdr_load   = out_active & advance & (out_cnt < HDR_CNT);
    assign pf_take    = out_active & advance & (out_cnt >= HDR_CNT) & (out_cnt < FRAME_CNT)
                        & pf_valid;
    // Reads start during the header so the first sample is waiting when the header ends
    assign rd_en      = out_active & (rd_cnt < WIN_CNT) & (~pf_valid | pf_take);
    assign rd_addr    = start_ptr + rd_cnt[PW-1:0];
    assign frame_done = (state == StData) & xfer & dout_last;
    assign busy       = (state != StArmed);

    sample_ring_ram #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Header word selected by the output load count
    always_comb begin
        hdr_word = '0;
        case (out_cnt[1:0])
            2'd0:    hdr_word = {HDR_MARKER, CH_ID};
            2'd1:    hdr_word = ts_lat[47:32];
            2'd2:    hdr_word = ts_lat[31:16];
            default: hdr_word = ts_lat[15:0];
        endcase
    end

    // Capture FSM, write pointer, trigger edge detect and drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StFill;
            trigger_d  <= 1'b0;
            wr_ptr     <= '0;
            start_ptr  <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            ts_lat     <= '0;
            drop_count <= '0;
        end else begin
            trigger_d <= trigger;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (trig_evt && (state != StArmed) && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            case (state)
                StFill: begin
                    if (enable) begin
                        fill_cnt <= fill_cnt + CW'(1);
                        if (fill_cnt + CW'(1) == PRE_CNT) begin
                            state <= StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (trig_evt) begin
                        ts_lat    <= timestamp;
                        start_ptr <= wr_ptr - PRE_OFS;
                        // A write in the trigger cycle is the trigger sample itself
                        if (enable && (POST_CNT == CW'(1))) begin
                            state <= StHdr;
                        end else begin
                            post_cnt <= enable ? CW'(1) : '0;
                            state    <= StPost;
                        end
                    end
                end
                StPost: begin
                    if (enable) begin
                        post_cnt <= post_cnt + CW'(1);
                        if (post_cnt + CW'(1) == POST_CNT) begin
                            state <= StHdr;
                        end
                    end
                end
                StHdr: begin
                    if (xfer && (out_cnt == HDR_CNT)) begin
                        state <= StData;
                    end
                end
                StData: begin
                    if (frame_done) begin
                        fill_cnt <= '0;
                        state    <= StFill;
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

    // Output stage: RAM read register acts as a one-deep prefetch behind the output register
    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt    <= '0;
            rd_cnt     <= '0;
            pf_valid   <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_cnt   <= rd_cnt + CW'(1);
                pf_valid <= 1'b1;
            end else if (pf_take) begin
                pf_valid <= 1'b0;
            end

            if (hdr_load) begin
                dout       <= hdr_word;
                dout_valid <= 1'b1;
                dout_last  <= 1'b0;
                out_cnt    <= out_cnt + CW'(1);
            end else if (pf_take) begin
                dout       <= rd_data;
                dout_valid <= 1'b1;
                dout_last  <= (out_cnt == FRAME_CNT - CW'(1));
                out_cnt    <= out_cnt + CW'(1);
            end else if (xfer) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end

            if (frame_done) begin
                out_cnt  <= '0;
                rd_cnt   <= '0;
                pf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_self_trigger_frame_capture.sv
// Directed bench for self_trigger_frame_capture: table of capture scenarios plus
// hand-written sequences for reset values, arming, FILL drops and reset mid-frame.
module tb_self_trigger_frame_capture;

    localparam int PRE = 64;
    localparam int WIN = 256;
    localparam int DEP = 512;
    localparam logic [15:0] HDR0 = 16'hA53C;  // marker A5, channel 0x3C

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic signed [15:0] din;
    logic               trigger;
    logic        [47:0] timestamp = 48'h0012_3456_7000;
    logic        [15:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               dout_last;
    logic               busy;
    logic        [15:0] drop_count;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int idx;
    int gap;
    int wr_cyc;
    int cur_vec;
    logic [47:0] last_ts;
    logic [47:0] ts_exp;
    logic [15:0] exp_q[$];

    typedef struct {
        int trig_idx;    // sample index (since reset) carrying the trigger rise
        int hold;        // samples trigger stays high
        int gap;         // clks per sample
        int ready_pct;   // percent of clks dout_ready is high
        int post_pulse;  // post-trigger sample offset with an extra rise (0 = none)
        int data_pulse;  // word count at which to pulse trigger while streaming (0 = none)
        int exp_drops;
    } vec_t;

    vec_t vecs[5];

    self_trigger_frame_capture #(
        .PRE_SAMPLES (PRE),
        .WINDOW      (WIN),
        .DEPTH       (DEP),
        .CHANNEL_ID  (32'h3C)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .din        (din),
        .trigger    (trigger),
        .timestamp  (timestamp),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Free-running time base; changes just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            timestamp = timestamp + 48'd1;
            cyc = cyc + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        trigger    = 1'b0;
        dout_ready = 1'b0;
        din        = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idx   = 0;
    endtask

    // One sample: gap-1 idle clks, then an enable clk carrying din=idx and the trigger level
    task automatic push(input bit trig);
        for (int i = 1; i < gap; i++) @(negedge clk);
        enable  = 1'b1;
        din     = 16'(idx);
        trigger = trig;
        last_ts = timestamp;
        @(negedge clk);
        enable = 1'b0;
        wr_cyc = cyc;
        idx++;
    endtask

    task automatic build_exp(input int trig_idx, input logic [47:0] ts);
        exp_q.delete();
        exp_q.push_back(HDR0);
        exp_q.push_back(ts[47:32]);
        exp_q.push_back(ts[31:16]);
        exp_q.push_back(ts[15:0]);
        for (int i = 0; i < WIN; i++) exp_q.push_back(16'(trig_idx - PRE + i));
    endtask

    // Collect one frame; optionally pulse trigger mid-stream or reset after abort_at words
    task automatic recv(input int ready_pct, input int data_pulse_at, input int abort_at);
        int n = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        bit done = 1'b0;
        bit prev_stall = 1'b0;
        logic [15:0] prev_dout = '0;
        logic prev_last = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            if (abort_at > 0 && n == abort_at) begin
                reset      = 1'b1;
                dout_ready = 1'b0;
                @(negedge clk);
                check("abort dout_valid", 64'(dout_valid), 64'd0);
                check("abort busy", 64'(busy), 64'd1);
                reset = 1'b0;
                return;
            end
            dout_ready = ($urandom_range(0, 99) < ready_pct);
            trigger    = (data_pulse_at > 0) && (n == data_pulse_at);
            if (prev_stall) begin
                check($sformatf("v%0d stall hold", cur_vec), {dout_valid, dout_last, dout},
                      {1'b1, prev_last, prev_dout});
            end
            if (dout_valid && first_cyc < 0) first_cyc = cyc;
            if (dout_valid && dout_ready) begin
                if (n < exp_q.size()) begin
                    check($sformatf("v%0d word %0d", cur_vec, n), {dout_last, dout},
                          {(n == exp_q.size() - 1), exp_q[n]});
                end else begin
                    check($sformatf("v%0d extra word", cur_vec), 64'(n), 64'(exp_q.size() - 1));
                end
                n++;
                if (dout_last) begin
                    done     = 1'b1;
                    last_cyc = cyc;
                end
            end
            prev_stall = dout_valid & ~dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
            @(negedge clk);
        end
        dout_ready = 1'b0;
        trigger    = 1'b0;
        check($sformatf("v%0d word count", cur_vec), 64'(n), 64'(exp_q.size()));
        check($sformatf("v%0d header latency<=2", cur_vec),
              64'(first_cyc >= 0 && first_cyc - wr_cyc <= 2), 64'd1);
        if (ready_pct == 100) begin
            check($sformatf("v%0d valid span", cur_vec), 64'(last_cyc - first_cyc + 1),
                  64'(exp_q.size()));
        end
    endtask

    // Fill to the trigger sample, write the post-trigger samples, then stream the frame
    task automatic run_frame(input vec_t v);
        gap = v.gap;
        while (idx < v.trig_idx) push(1'b0);
        push(1'b1);
        ts_exp = last_ts;
        for (int k = 1; k < WIN - PRE; k++) begin
            push((k < v.hold) || (v.post_pulse > 0 && k == v.post_pulse));
        end
        build_exp(v.trig_idx, ts_exp);
        recv(v.ready_pct, v.data_pulse, 0);
    endtask

    initial begin
        // Trigger at 1000: data 936..1191 with enable every 4 clks
        vecs[0] = '{trig_idx: 1000, hold: 1, gap: 4, ready_pct: 100, post_pulse: 0,
                    data_pulse: 0, exp_drops: 0};
        // 532 writes puts wr_ptr at 20: window starts at ring address 468 and wraps
        vecs[1] = '{trig_idx: 532, hold: 1, gap: 1, ready_pct: 100, post_pulse: 0,
                    data_pulse: 0, exp_drops: 0};
        vecs[2] = '{trig_idx: 100, hold: 1, gap: 1, ready_pct: 30, post_pulse: 0,
                    data_pulse: 0, exp_drops: 0};
        vecs[3] = '{trig_idx: 300, hold: 128, gap: 1, ready_pct: 100, post_pulse: 0,
                    data_pulse: 0, exp_drops: 0};
        vecs[4] = '{trig_idx: 200, hold: 1, gap: 1, ready_pct: 100, post_pulse: 50,
                    data_pulse: 20, exp_drops: 2};

        // Reset values and arming point
        cur_vec = -1;
        do_reset();
        check("reset dout", 64'(dout), 64'd0);
        check("reset dout_valid", 64'(dout_valid), 64'd0);
        check("reset dout_last", 64'(dout_last), 64'd0);
        check("reset busy", 64'(busy), 64'd1);
        check("reset drop_count", 64'(drop_count), 64'd0);
        gap = 1;
        repeat (PRE - 1) push(1'b0);
        check("busy after 63 writes", 64'(busy), 64'd1);
        push(1'b0);
        check("armed after 64 writes", 64'(busy), 64'd0);

        for (int i = 0; i < 5; i++) begin
            cur_vec = i;
            do_reset();
            run_frame(vecs[i]);
            check($sformatf("v%0d drop_count", i), 64'(drop_count), 64'(vecs[i].exp_drops));
        end

        // Trigger while refilling after a frame: counted as a drop, no frame follows
        cur_vec = 5;
        gap = 1;
        repeat (5) push(1'b0);
        push(1'b1);
        repeat (5) push(1'b0);
        check("fill drop_count", 64'(drop_count), 64'd3);
        check("fill busy", 64'(busy), 64'd1);
        begin
            int nv = 0;
            dout_ready = 1'b1;
            repeat (40) begin
                @(negedge clk);
                if (dout_valid) nv++;
            end
            dout_ready = 1'b0;
            check("fill no frame", 64'(nv), 64'd0);
        end

        // Reset while the 10th data word is on the output
        cur_vec = 6;
        do_reset();
        gap = 1;
        while (idx < 200) push(1'b0);
        push(1'b1);
        ts_exp = last_ts;
        for (int k = 1; k < WIN - PRE; k++) push(1'b0);
        build_exp(200, ts_exp);
        recv(100, 0, 13);
        check("post-abort drop_count", 64'(drop_count), 64'd0);
        idx = 0;
        repeat (30) push(1'b0);
        push(1'b1);
        while (idx < PRE) push(1'b0);
        check("early trigger dropped", 64'(drop_count), 64'd1);
        check("re-armed after 64", 64'(busy), 64'd0);
        cur_vec = 7;
        while (idx < 100) push(1'b0);
        push(1'b1);
        ts_exp = last_ts;
        for (int k = 1; k < WIN - PRE; k++) push(1'b0);
        build_exp(100, ts_exp);
        recv(100, 0, 0);
        check("final drop_count", 64'(drop_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/self_trigger_frame_capture.md
# self_trigger_frame_capture

Downstream consumer of the IIR self-trigger filter stage. Keeps a circular history of raw ADC samples, and on a rising edge of the filter's `trigger` freezes a window with programmable pre-trigger depth. It then streams the window as a framed 16-bit valid/ready packet: header carrying channel ID and trigger timestamp, followed by samples. The packet goes to the readout/spy-buffer logic.

## Interface
- `PRE_SAMPLES`, 64: samples kept before the trigger sample; 1..WINDOW-1.
- `WINDOW`, 256: samples per frame, trigger sample included; ≤ DEPTH/2.
- `DEPTH`, 512: ring buffer depth; power of two.
- `CHANNEL_ID`, 0: 8-bit channel number placed in the header.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: sample strobe; same strobe that drives the filter.
- `din` in 16 signed: raw sample, already aligned to the filter trigger latency.
- `trigger` in 1: filter trigger level; may stay high for many samples.
- `timestamp` in 48: free-running time counter.
- `dout` out 16: frame word.
- `dout_valid` out 1: `dout` is valid.
- `dout_ready` in 1: consumer accepts the word.
- `dout_last` out 1: final word of the frame.
- `busy` out 1: high in every state except ARMED.
- `drop_count` out 16: triggers rejected since reset; saturates at 0xFFFF.

## Operation
- Write side: in FILL, ARMED and POST, each `enable` cycle writes `din` at `wr_ptr`, then `wr_ptr` increments modulo DEPTH. No writes occur in HDR or DATA; `wr_ptr` holds.
- Trigger event: `trigger & ~trigger_d`, where `trigger_d` is `trigger` registered every clk. The event is evaluated every clk, independent of `enable`.
- States:
  - FILL: count `enable` writes. After PRE_SAMPLES writes → ARMED.
  - ARMED: on a trigger event, latch `ts_lat <= timestamp` and `start_ptr <= wr_ptr - PRE_SAMPLES` (mod DEPTH) → POST.
    - If `enable` is high in the same cycle, that write is the trigger sample and counts as the first POST write.
  - POST: count writes until WINDOW-PRE_SAMPLES post-trigger writes (trigger sample included) → HDR.
  - HDR: emit 4 header words in order:
    - 0xA5, CHANNEL_ID
    - ts[47:32]
    - ts[31:16]
    - ts[15:0]
    - Then → DATA.
  - DATA: emit WINDOW samples starting at `start_ptr`, read pointer wrapping modulo DEPTH. `dout_last` is asserted with the final sample. On acceptance of the final sample → FILL, with the fill counter cleared.
- Trigger events in FILL, POST, HDR or DATA increment `drop_count`. They are not queued.
- Handshake:
  - A word transfers when `dout_valid & dout_ready`.
  - While `dout_valid & ~dout_ready`, `dout` and `dout_last` hold stable.
  - `dout_valid` never drops without a transfer.
- RAM read latency is 1 clk. The output stage prefetches so that back-to-back transfers at one word/clk are sustained when `dout_ready` is held high.
- Reset mid-frame: the frame is abandoned with no further words. All state clears and operation restarts in FILL.

## Timing
- Reset values:
  - `dout` = 0, `dout_valid` = 0, `dout_last` = 0.
  - `busy` = 1 (state FILL).
  - `drop_count` = 0, `wr_ptr` = 0.
- ARMED is reached on the clk after the PRE_SAMPLES-th `enable` write following reset or frame end.
- First header word is valid no later than 2 clk after the final POST write.
- With `dout_ready` held high, a frame occupies exactly 4+WINDOW consecutive valid clks.
- Dead time from trigger to re-arm: the POST writes, plus 4+WINDOW transfers, plus PRE_SAMPLES `enable` writes.

## Structure
- Shared package:
  - header marker 8'hA5
  - header length 4
  - state enum {FILL, ARMED, POST, HDR, DATA}
  - pointer width function clog2(DEPTH)
- Sub-module `sample_ring_ram`: simple dual-port, 16×DEPTH, registered read, 1-clk latency. This infers block RAM.
- All control logic, pointer arithmetic and the output register stay in the top module.

## Test plan
- Ramp: `din` = sample index, `enable` every 4 clk, PRE=64, WINDOW=256. Trigger rises at sample 1000 → header A5xx plus latched ts, then samples 936..1191; `dout_last` on 1191.
- Wrap: trigger at a `wr_ptr` of 20 → data starts at ring address 468 (DEPTH 512), and sample values are contiguous across the wrap.
- Backpressure: `dout_ready` random 30% → word sequence identical to the no-stall run; no word is duplicated or lost; `dout` is stable during stalls.
- Drops: second trigger rise during POST, third during DATA → `drop_count` = 2; only one frame is emitted. A trigger during FILL after the frame also counts, and no frame follows it.
- Held trigger: `trigger` high for 128 samples → exactly one frame and no drop counted.
- Reset at the 10th DATA word → `dout_valid` is 0 on the next clk. After reset, the next trigger is ignored until 64 writes complete. It then yields a correct frame.
